// File: rtl/wm8731_i2s_ctrl.sv
// -----------------------------------------------------------------------------
// wm8731_i2s_ctrl
//
// I2S audio-interface master for a WM8731 codec running in slave mode.
// Derives BCLK and a shared ADC/DAC LRCLK from the system clock, serialises
// stereo DAC samples taken over a valid/ready handshake, and deserialises ADC
// samples into a registered stereo word with a one-cycle valid strobe.
//
// Frame layout: 2*SLOT_W BCLK periods per frame, left slot first (LRCLK low).
// Inside each slot, positions 1..DATA_W carry the sample MSB first (I2S puts
// the MSB one BCLK after the LR edge). All other positions are zero.
// Data and LRCLK change on BCLK falls, and the codec samples on BCLK rises.
//
// Ports
//   iCLK, iRST_N          system clock, asynchronous active-low reset
//   en                    run enable (configuration-done flag)
//   dac_l, dac_r          DAC sample pair, two's complement
//   dac_valid, dac_ready  handshake into the single-entry holding register
//   adc_l, adc_r          last captured ADC pair
//   adc_valid             one-cycle strobe when adc_l/adc_r update
//   underrun              one-cycle strobe: frame started with nothing held
//   WM_BCLK               bit clock to the codec
//   WM_ADCLRC, WM_DACLRC  LR clock (identical)
//   WM_DACDAT             serial DAC data to the codec
//   WM_ADCDAT             serial ADC data from the codec (asynchronous)
//
// Parameters: CLK_DIV >= 4, SLOT_W >= DATA_W+1, DATA_W >= 2.
// -----------------------------------------------------------------------------
module wm8731_i2s_ctrl #(
    parameter int CLK_DIV = 8,
    parameter int SLOT_W  = 32,
    parameter int DATA_W  = 16
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              en,
    input  logic [DATA_W-1:0] dac_l,
    input  logic [DATA_W-1:0] dac_r,
    input  logic              dac_valid,
    output logic              dac_ready,
    output logic [DATA_W-1:0] adc_l,
    output logic [DATA_W-1:0] adc_r,
    output logic              adc_valid,
    output logic              underrun,
    output logic              WM_BCLK,
    output logic              WM_ADCLRC,
    output logic              WM_DACLRC,
    output logic              WM_DACDAT,
    input  logic              WM_ADCDAT
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(2 * SLOT_W);
    localparam int TX_W  = 2 * DATA_W;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(2 * SLOT_W - 1);
    localparam logic [BIT_W-1:0] SLOT_LEN  = BIT_W'(SLOT_W);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_W);

    // Position of a BCLK period inside its channel slot.
    function automatic logic [BIT_W-1:0] slot_pos(input logic [BIT_W-1:0] idx);
        return (idx >= SLOT_LEN) ? idx - SLOT_LEN : idx;
    endfunction

    // Positions 1..DATA_W carry sample bits, everything else is padding.
    function automatic logic is_data_pos(input logic [BIT_W-1:0] pos);
        return (pos != '0) && (pos <= LAST_DATA);
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DIV_W-1:0]  div_cnt_q,   div_cnt_d;
    logic              bclk_q,      bclk_d;
    logic [BIT_W-1:0]  bit_cnt_q,   bit_cnt_d;
    logic              lrclk_q,     lrclk_d;
    logic              dacdat_q,    dacdat_d;
    logic [TX_W-1:0]   tx_sh_q,     tx_sh_d;
    logic [DATA_W-1:0] hold_l_q,    hold_l_d;
    logic [DATA_W-1:0] hold_r_q,    hold_r_d;
    logic              hold_full_q, hold_full_d;
    logic              underrun_q,  underrun_d;
    logic [1:0]        adc_sync_q,  adc_sync_d;
    logic [DATA_W-1:0] rx_l_q,      rx_l_d;
    logic [DATA_W-1:0] rx_r_q,      rx_r_d;
    logic [DATA_W-1:0] adc_l_q,     adc_l_d;
    logic [DATA_W-1:0] adc_r_q,     adc_r_d;
    logic              adc_valid_q, adc_valid_d;

    // ------------------------------------------------------------------------
    // Shared decodes
    // ------------------------------------------------------------------------
    logic             fall_evt;     // this cycle's toggle takes BCLK 1->0
    logic             frame_start;  // fall event that wraps bit_cnt to 0
    logic             accept;       // handshake completes this cycle
    logic             cur_right;    // period ending now lies in the right slot
    logic [BIT_W-1:0] bit_nxt;      // period index after this fall event
    logic [BIT_W-1:0] pos_cur;      // slot position of the period ending now
    logic [BIT_W-1:0] pos_nxt;      // slot position of the period starting

    always_comb begin
        fall_evt    = en && bclk_q && (div_cnt_q == DIV_LAST);
        frame_start = fall_evt && (bit_cnt_q == BIT_LAST);
        accept      = dac_valid && !hold_full_q;
        cur_right   = (bit_cnt_q >= SLOT_LEN);
        bit_nxt     = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_W'(1);
        pos_cur     = slot_pos(bit_cnt_q);
        pos_nxt     = slot_pos(bit_nxt);
    end

    // ------------------------------------------------------------------------
    // Clock generation: BCLK divider, period index and LRCLK
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise an unassigned path would infer a latch.
        div_cnt_d = div_cnt_q;
        bclk_d    = bclk_q;
        bit_cnt_d = bit_cnt_q;
        lrclk_d   = lrclk_q;

        if (!en) begin
            // Disabling parks the codec clocks low and restarts the frame.
            div_cnt_d = '0;
            bclk_d    = 1'b0;
            bit_cnt_d = '0;
            lrclk_d   = 1'b0;
        end else begin
            if (div_cnt_q == DIV_LAST) begin
                div_cnt_d = '0;
                bclk_d    = !bclk_q;
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end

            if (fall_evt) begin
                bit_cnt_d = bit_nxt;
                // Registered, so LRCLK moves together with the BCLK fall.
                lrclk_d   = (bit_nxt >= SLOT_LEN);
            end
        end
    end

    // ------------------------------------------------------------------------
    // DAC path: holding register, frame-start load and serialiser
    // ------------------------------------------------------------------------
    always_comb begin
        tx_sh_d     = tx_sh_q;
        dacdat_d    = dacdat_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        hold_full_d = hold_full_q;
        underrun_d  = 1'b0;

        if (!en) begin
            tx_sh_d  = '0;
            dacdat_d = 1'b0;
        end else if (fall_evt) begin
            if (frame_start) begin
                if (hold_full_q) begin
                    tx_sh_d     = {hold_l_q, hold_r_q};
                    hold_full_d = 1'b0;
                end else begin
                    tx_sh_d    = '0;
                    underrun_d = 1'b1;
                end
                dacdat_d = 1'b0;
            end else if (is_data_pos(pos_nxt)) begin
                // {L, R} shifts out MSB first; after DATA_W left-slot shifts
                // the right sample sits at the top for the right slot.
                dacdat_d = tx_sh_q[TX_W-1];
                tx_sh_d  = {tx_sh_q[TX_W-2:0], 1'b0};
            end else begin
                dacdat_d = 1'b0;
            end
        end

        // Accepting is only possible while empty, so it never collides with
        // the frame-start drain above. The holding register survives en=0.
        if (accept) begin
            hold_l_d    = dac_l;
            hold_r_d    = dac_r;
            hold_full_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // ADC path: synchroniser, deserialiser and output register
    // ------------------------------------------------------------------------
    always_comb begin
        adc_sync_d  = {adc_sync_q[0], WM_ADCDAT};
        rx_l_d      = rx_l_q;
        rx_r_d      = rx_r_q;
        adc_l_d     = adc_l_q;
        adc_r_d     = adc_r_q;
        adc_valid_d = 1'b0;

        if (!en) begin
            // Partial words are dropped; adc_l/adc_r keep the last good pair.
            rx_l_d = '0;
            rx_r_d = '0;
        end else if (fall_evt && is_data_pos(pos_cur)) begin
            // Capture at the end of the period, well after the codec has
            // driven the bit and the synchroniser has settled.
            if (cur_right) begin
                rx_r_d = {rx_r_q[DATA_W-2:0], adc_sync_q[1]};
            end else begin
                rx_l_d = {rx_l_q[DATA_W-2:0], adc_sync_q[1]};
            end

            // Last right-channel bit: publish the pair, including that bit.
            if (cur_right && (pos_cur == LAST_DATA)) begin
                adc_l_d     = rx_l_q;
                adc_r_d     = {rx_r_q[DATA_W-2:0], adc_sync_q[1]};
                adc_valid_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the values from before this edge.
    // NOTE: the holding and shift registers are plain flops, not RAM, so they
    // are cleared in reset along with the control state.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            div_cnt_q   <= '0;
            bclk_q      <= 1'b0;
            bit_cnt_q   <= '0;
            lrclk_q     <= 1'b0;
            dacdat_q    <= 1'b0;
            tx_sh_q     <= '0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            hold_full_q <= 1'b0;
            underrun_q  <= 1'b0;
            adc_sync_q  <= '0;
            rx_l_q      <= '0;
            rx_r_q      <= '0;
            adc_l_q     <= '0;
            adc_r_q     <= '0;
            adc_valid_q <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            bclk_q      <= bclk_d;
            bit_cnt_q   <= bit_cnt_d;
            lrclk_q     <= lrclk_d;
            dacdat_q    <= dacdat_d;
            tx_sh_q     <= tx_sh_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            hold_full_q <= hold_full_d;
            underrun_q  <= underrun_d;
            adc_sync_q  <= adc_sync_d;
            rx_l_q      <= rx_l_d;
            rx_r_q      <= rx_r_d;
            adc_l_q     <= adc_l_d;
            adc_r_q     <= adc_r_d;
            adc_valid_q <= adc_valid_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign dac_ready = !hold_full_q;
    assign adc_l     = adc_l_q;
    assign adc_r     = adc_r_q;
    assign adc_valid = adc_valid_q;
    assign underrun  = underrun_q;
    assign WM_BCLK   = bclk_q;
    assign WM_ADCLRC = lrclk_q;
    assign WM_DACLRC = lrclk_q;
    assign WM_DACDAT = dacdat_q;

endmodule

// File: tb/tb_wm8731_i2s_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wm8731_i2s_ctrl
//
// The reference model works from the frame arithmetic: counting iCLK edges
// since enable, u = t+1 gives BCLK = (u/CLK_DIV) mod 2, the period index
// (u/(2*CLK_DIV)) mod (2*SLOT_W), and the frame number u/frame_len. Serial
// bits, LRCLK, underrun and adc_valid timing all follow from that. The bench
// drives ADC bits per period from a random pair (or loops DACDAT back), and
// checks every output every cycle. A segment table adds hand-derived
// underrun/adc_valid counts for the directed scenarios.
// -----------------------------------------------------------------------------
module tb_wm8731_i2s_ctrl;

    localparam int CLK_DIV = 8;
    localparam int SLOT_W  = 32;
    localparam int DATA_W  = 16;
    localparam int PER     = 2 * CLK_DIV;              // iCLK per BCLK
    localparam int FRAME   = 2 * SLOT_W * PER;         // iCLK per frame
    localparam int VALID_U = (SLOT_W + DATA_W + 1) * PER;

    logic              iCLK      = 1'b0;
    logic              iRST_N    = 1'b0;
    logic              en        = 1'b0;
    logic [DATA_W-1:0] dac_l     = '0;
    logic [DATA_W-1:0] dac_r     = '0;
    logic              dac_valid = 1'b0;
    logic              dac_ready;
    logic [DATA_W-1:0] adc_l;
    logic [DATA_W-1:0] adc_r;
    logic              adc_valid;
    logic              underrun;
    logic              WM_BCLK;
    logic              WM_ADCLRC;
    logic              WM_DACLRC;
    logic              WM_DACDAT;
    logic              WM_ADCDAT;
    logic              adc_drv   = 1'b0;
    logic              loop      = 1'b0;

    assign WM_ADCDAT = loop ? WM_DACDAT : adc_drv;

    wm8731_i2s_ctrl #(
        .CLK_DIV (CLK_DIV),
        .SLOT_W  (SLOT_W),
        .DATA_W  (DATA_W)
    ) dut (
        .iCLK      (iCLK),
        .iRST_N    (iRST_N),
        .en        (en),
        .dac_l     (dac_l),
        .dac_r     (dac_r),
        .dac_valid (dac_valid),
        .dac_ready (dac_ready),
        .adc_l     (adc_l),
        .adc_r     (adc_r),
        .adc_valid (adc_valid),
        .underrun  (underrun),
        .WM_BCLK   (WM_BCLK),
        .WM_ADCLRC (WM_ADCLRC),
        .WM_DACLRC (WM_DACLRC),
        .WM_DACDAT (WM_DACDAT),
        .WM_ADCDAT (WM_ADCDAT)
    );

    always #5 iCLK = ~iCLK;

    // ------------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    bit                run   = 1'b0;   // enabled on the last edge
    int                t     = 0;      // edges since en was first seen high
    bit                m_full = 1'b0;
    logic [DATA_W-1:0] m_hl = '0, m_hr = '0;     // held pair
    logic [DATA_W-1:0] cur_l = '0, cur_r = '0;   // pair of the current frame
    logic [DATA_W-1:0] ai_l = '0, ai_r = '0;     // ADC pair sent this frame
    logic [DATA_W-1:0] m_al = '0, m_ar = '0;     // expected adc_l/adc_r
    bit                e_bclk, e_lr, e_dat, e_under, e_valid;
    bit                last_accept;
    int                cnt_under, cnt_valid;

    task automatic model_edge(input logic e, input logic v,
                              input logic [DATA_W-1:0] l,
                              input logic [DATA_W-1:0] r);
        bit old_full;
        int u, idx, p;
        old_full    = m_full;
        last_accept = v && !old_full;
        e_under     = 1'b0;
        e_valid     = 1'b0;
        if (!e) begin
            run    = 1'b0;
            e_bclk = 1'b0;
            e_lr   = 1'b0;
            e_dat  = 1'b0;
        end else begin
            if (!run) begin
                run   = 1'b1;
                t     = 0;
                cur_l = '0;
                cur_r = '0;
                ai_l  = 16'($urandom);
                ai_r  = 16'($urandom);
            end else begin
                t++;
            end
            u      = t + 1;
            idx    = (u / PER) % (2 * SLOT_W);
            p      = idx % SLOT_W;
            e_bclk = ((u / CLK_DIV) % 2) == 1;
            e_lr   = idx >= SLOT_W;
            if (u % FRAME == 0) begin
                ai_l = 16'($urandom);
                ai_r = 16'($urandom);
                if (old_full) begin
                    cur_l  = m_hl;
                    cur_r  = m_hr;
                    m_full = 1'b0;
                end else begin
                    cur_l   = '0;
                    cur_r   = '0;
                    e_under = 1'b1;
                end
            end
            if (p >= 1 && p <= DATA_W)
                e_dat = e_lr ? cur_r[DATA_W-p] : cur_l[DATA_W-p];
            else
                e_dat = 1'b0;
            if (u % FRAME == VALID_U) begin
                e_valid = 1'b1;
                m_al    = loop ? cur_l : ai_l;
                m_ar    = loop ? cur_r : ai_r;
            end
        end
        if (last_accept) begin
            m_hl   = l;
            m_hr   = r;
            m_full = 1'b1;
        end
    endtask

    // Codec side: present the bit of the period that has just begun.
    task automatic drive_adc();
        int u, idx, p;
        adc_drv = 1'($urandom);
        if (run) begin
            u   = t + 1;
            idx = (u / PER) % (2 * SLOT_W);
            p   = idx % SLOT_W;
            if (p >= 1 && p <= DATA_W)
                adc_drv = (idx >= SLOT_W) ? ai_r[DATA_W-p] : ai_l[DATA_W-p];
        end
    endtask

    // One iCLK cycle: model the edge, then compare all outputs 1 ns later.
    task automatic step();
        @(posedge iCLK);
        model_edge(en, dac_valid, dac_l, dac_r);
        #1;
        check("bclk",      32'(WM_BCLK),   32'(e_bclk));
        check("adclrc",    32'(WM_ADCLRC), 32'(e_lr));
        check("daclrc",    32'(WM_DACLRC), 32'(e_lr));
        check("dacdat",    32'(WM_DACDAT), 32'(e_dat));
        check("underrun",  32'(underrun),  32'(e_under));
        check("adc_valid", 32'(adc_valid), 32'(e_valid));
        check("dac_ready", 32'(dac_ready), 32'(!m_full));
        check("adc_l",     32'(adc_l),     32'(m_al));
        check("adc_r",     32'(adc_r),     32'(m_ar));
        if (underrun)  cnt_under++;
        if (adc_valid) cnt_valid++;
        drive_adc();
    endtask

    // ------------------------------------------------------------------------
    // Directed segment table
    // ------------------------------------------------------------------------
    typedef struct {
        string             name;
        int                cycles;
        logic              en;
        logic              loop;
        int                n_offer;   // pairs offered back to back
        logic [DATA_W-1:0] l;
        logic [DATA_W-1:0] r;         // second offer uses ~l / ~r
        int                exp_under;
        int                exp_valid;
    } seg_t;

    localparam int N_SEG = 8;
    seg_t segs [N_SEG];

    task automatic set_seg(input int i, input string name, input int cycles,
                           input logic e, input logic lp, input int n_offer,
                           input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                           input int exp_under, input int exp_valid);
        segs[i].name      = name;
        segs[i].cycles    = cycles;
        segs[i].en        = e;
        segs[i].loop      = lp;
        segs[i].n_offer   = n_offer;
        segs[i].l         = l;
        segs[i].r         = r;
        segs[i].exp_under = exp_under;
        segs[i].exp_valid = exp_valid;
    endtask

    initial begin
        int offered;
        int dis_at, dis_len;

        //       idx name            cycles en  loop offers L        R        und val
        set_seg(0, "idle",          2000, 1'b0, 1'b0, 0, 16'h0000, 16'h0000, 0, 0);
        set_seg(1, "first_frame",   1024, 1'b1, 1'b0, 1, 16'hA5F0, 16'h1234, 0, 1);
        set_seg(2, "dac_frame1",    1024, 1'b1, 1'b1, 0, 16'h0000, 16'h0000, 1, 1);
        set_seg(3, "loopback",      2048, 1'b1, 1'b1, 1, 16'h8001, 16'h7FFE, 1, 2);
        set_seg(4, "backpressure",  3072, 1'b1, 1'b0, 2, 16'hC3C3, 16'h5A5A, 1, 3);
        set_seg(5, "run_to_bit20",   320, 1'b1, 1'b0, 1, 16'hBEEF, 16'h0F0F, 0, 0);
        set_seg(6, "disabled",       100, 1'b0, 1'b0, 0, 16'h0000, 16'h0000, 0, 0);
        set_seg(7, "restart",       2048, 1'b1, 1'b1, 0, 16'h0000, 16'h0000, 1, 2);

        // Reset state
        repeat (5) @(posedge iCLK);
        #1;
        check("rst_dac_ready", 32'(dac_ready), 32'd1);
        check("rst_bclk",      32'(WM_BCLK),   32'd0);
        check("rst_lrclk",     32'({WM_ADCLRC, WM_DACLRC}), 32'd0);
        check("rst_dacdat",    32'(WM_DACDAT), 32'd0);
        check("rst_adc",       32'({adc_l, adc_r}), 32'd0);
        check("rst_strobes",   32'({adc_valid, underrun}), 32'd0);
        iRST_N = 1'b1;

        for (int i = 0; i < N_SEG; i++) begin
            offered   = 0;
            cnt_under = 0;
            cnt_valid = 0;
            en        = segs[i].en;
            loop      = segs[i].loop;
            for (int c = 0; c < segs[i].cycles; c++) begin
                if (offered < segs[i].n_offer) begin
                    dac_valid = 1'b1;
                    dac_l     = (offered == 0) ? segs[i].l : ~segs[i].l;
                    dac_r     = (offered == 0) ? segs[i].r : ~segs[i].r;
                end else begin
                    dac_valid = 1'b0;
                end
                step();
                if (last_accept) offered++;
            end
            dac_valid = 1'b0;
            check({segs[i].name, "_offers_taken"}, 32'(offered), 32'(segs[i].n_offer));
            check({segs[i].name, "_underruns"}, 32'(cnt_under), 32'(segs[i].exp_under));
            check({segs[i].name, "_adc_valids"}, 32'(cnt_valid), 32'(segs[i].exp_valid));
        end

        // Randomised run: sparse offers, offers aimed at frame-start cycles,
        // random ADC data and one random mid-frame disable.
        loop    = 1'b0;
        dis_at  = int'($urandom_range(3000, 6000));
        dis_len = int'($urandom_range(1, 40));
        for (int c = 0; c < 8192; c++) begin
            en = !(c >= dis_at && c < dis_at + dis_len);
            if (run && ((t + 2) % FRAME == 0))
                dac_valid = 1'($urandom);
            else
                dac_valid = ($urandom_range(0, 399) == 0);
            dac_l = 16'($urandom);
            dac_r = 16'($urandom);
            step();
        end
        dac_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
